// File: rtl/mipi_frame_arbiter.sv
// Per-frame arbiter sharing one MIPI packet port between the host SLIP stream and the
// local packet source, with an enforced LP idle gap and a stall watchdog that drains stuck frames.
module mipi_frame_arbiter #(
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 4096,
  parameter int CW         = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       h_frame,
  input  logic [7:0] h_data,
  input  logic       h_rdy,
  output logic       h_ack,
  input  logic       l_frame,
  input  logic [7:0] l_data,
  input  logic       l_rdy,
  output logic       l_ack,
  output logic       m_frame,
  output logic [7:0] m_data,
  output logic       m_req,
  input  logic       m_ack,
  output logic [1:0] grant,
  output logic       err_timeout,
  output logic [7:0] abort_cnt
);

  // state | meaning
  // IDLE  | no owner, arbitrate pending frames (round-robin on contention)
  // HOST  | host stream owns the link
  // LOCAL | local packet source owns the link
  // ABORT | owner stalled; its bytes are discarded until its frame drops
  // GAP   | enforced LP idle between frames

  typedef enum logic [2:0] {S_IDLE, S_HOST, S_LOCAL, S_ABORT, S_GAP} state_t;

  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] WD_LOAD  = CW'(TIMEOUT - 1);
  localparam bit            WD_EN    = (TIMEOUT != 0);

  state_t        state_q, state_d;
  logic          last_q, last_d;   // 1 = local source was granted last
  logic [CW-1:0] wd_q, wd_d;
  logic [CW-1:0] gap_q, gap_d;
  logic          err_q, err_d;
  logic [7:0]    abort_q, abort_d;
  logic          own_frame;
  logic          wd_expire;

  assign own_frame = last_q ? l_frame : h_frame;
  assign wd_expire = WD_EN && !m_ack && (wd_q == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  // Timers are down-counters reloaded outside the states that run them.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wd_d    = WD_LOAD;
    gap_d   = GAP_LOAD;
    case (state_q)
      S_IDLE: begin
        if (h_frame && (!l_frame || last_q)) begin
          state_d = S_HOST;
          last_d  = 1'b0;
        end else if (l_frame) begin
          state_d = S_LOCAL;
          last_d  = 1'b1;
        end
      end
      S_HOST, S_LOCAL: begin
        if (!m_ack) wd_d = wd_q - CW'(1);
        if (!own_frame)     state_d = S_GAP;
        else if (wd_expire) state_d = S_ABORT;
      end
      S_ABORT: begin
        if (!own_frame) state_d = S_GAP;
      end
      S_GAP: begin
        gap_d = gap_q - CW'(1);
        if (gap_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    err_d   = (state_d == S_ABORT) && (state_q != S_ABORT);
    abort_d = (err_d && (abort_q != 8'hFF)) ? abort_q + 8'd1 : abort_q;
  end

  always_comb begin
    m_frame = 1'b0;
    m_data  = '0;
    m_req   = 1'b0;
    h_ack   = 1'b0;
    l_ack   = 1'b0;
    grant   = '0;
    case (state_q)
      S_HOST: begin
        m_frame = h_frame;
        m_data  = h_data;
        m_req   = h_rdy;
        h_ack   = m_ack;
        grant   = 2'b01;
      end
      S_LOCAL: begin
        m_frame = l_frame;
        m_data  = l_data;
        m_req   = l_rdy;
        l_ack   = m_ack;
        grant   = 2'b10;
      end
      S_ABORT: begin
        grant = last_q ? 2'b10 : 2'b01;
        h_ack = !last_q && h_rdy;
        l_ack = last_q && l_rdy;
      end
      default: ;
    endcase
  end

  assign err_timeout = err_q;
  assign abort_cnt   = abort_q;

endmodule

// File: tb/tb_mipi_frame_arbiter.sv
// Scenario bench for mipi_frame_arbiter: random byte streams and ack patterns checked
// against a round-robin / gap / timeout reference kept in plain variables.
module tb_mipi_frame_arbiter;

  localparam int GAP = 16;
  localparam int TMO = 8;

  logic       clk, nrst;
  logic       h_frame, h_rdy, h_ack;
  logic [7:0] h_data;
  logic       l_frame, l_rdy, l_ack;
  logic [7:0] l_data;
  logic       m_frame, m_req, m_ack;
  logic [7:0] m_data;
  logic [1:0] grant;
  logic       err_timeout;
  logic [7:0] abort_cnt;

  int n_run  = 0;
  int n_fail = 0;
  bit model_last;     // 1 = local granted last
  int model_aborts;

  mipi_frame_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TMO), .CW(16)) dut (
    .clk(clk), .nrst(nrst),
    .h_frame(h_frame), .h_data(h_data), .h_rdy(h_rdy), .h_ack(h_ack),
    .l_frame(l_frame), .l_data(l_data), .l_rdy(l_rdy), .l_ack(l_ack),
    .m_frame(m_frame), .m_data(m_data), .m_req(m_req), .m_ack(m_ack),
    .grant(grant), .err_timeout(err_timeout), .abort_cnt(abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] onehot(input bit src);
    return src ? 2'b10 : 2'b01;
  endfunction

  function automatic bit pick_owner(input bit h, input bit l);
    if (h && l) return !model_last;
    return l && !h;
  endfunction

  function automatic logic [7:0] sat_aborts();
    return (model_aborts > 255) ? 8'd255 : 8'(model_aborts);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    h_frame = 0; l_frame = 0; h_rdy = 0; l_rdy = 0; m_ack = 0;
    repeat (n) cyc();
  endtask

  // Counts grant-free clocks until an owner appears, then checks who and how long.
  task automatic wait_grant(input bit src, input int gap_exp, input string name);
    int cnt = 0;
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (grant !== 2'b00) got = 1;
      else begin
        cnt++;
        cyc();
      end
    end
    n_run++;
    if (!got || cnt != gap_exp) begin
      n_fail++;
      $display("FAIL %s gap_len: got %0d idle clocks (granted=%0b), want %0d", name, cnt, got, gap_exp);
    end
    n_run++;
    if (grant !== onehot(src) || m_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL %s grant: got grant=%b m_frame=%b, want grant=%b m_frame=1", name, grant, m_frame, onehot(src));
    end
    model_last = src;
    cyc();
  endtask

  // Streams n random bytes from the owner with random rdy/ack, then drops its frame.
  task automatic xfer(input bit src, input int n, input string name);
    logic [7:0] q[$];
    int idx = 0;
    int misses = 1;
    bit rdy, ack;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    for (int c = 0; c < 400 && idx < n; c++) begin
      rdy = (misses >= 2) || ($urandom_range(0, 3) != 0);
      ack = rdy && ((misses >= 2) || ($urandom_range(0, 1) == 1));
      if (src) begin
        l_rdy = rdy; l_data = q[idx]; h_rdy = 1; h_data = 8'($urandom);
      end else begin
        h_rdy = rdy; h_data = q[idx]; l_rdy = 1; l_data = 8'($urandom);
      end
      m_ack = ack;
      @(negedge clk);
      n_run++;
      if ({m_frame, m_req, h_ack, l_ack, grant} !== {1'b1, rdy, ack && !src, ack && src, onehot(src)}) begin
        n_fail++;
        $display("FAIL %s ctl byte %0d: got frame/req/hack/lack/grant=%b%b%b%b%b, want 1%b%b%b%b",
                 name, idx, m_frame, m_req, h_ack, l_ack, grant, rdy, ack && !src, ack && src, onehot(src));
      end
      if (rdy) begin
        n_run++;
        if (m_data !== q[idx]) begin
          n_fail++;
          $display("FAIL %s data byte %0d: got %h, want %h", name, idx, m_data, q[idx]);
        end
      end
      cyc();
      if (ack) begin
        idx++;
        misses = 0;
      end else misses++;
    end
    n_run++;
    if (idx != n) begin
      n_fail++;
      $display("FAIL %s bytes: got %0d accepted, want %0d", name, idx, n);
    end
    if (src) l_frame = 0; else h_frame = 0;
    h_rdy = 0; l_rdy = 0; m_ack = 0;
    @(negedge clk);
    n_run++;
    if ({m_frame, m_req, h_ack, l_ack, grant} !== {4'b0000, onehot(src)}) begin
      n_fail++;
      $display("FAIL %s drop: got frame/req/hack/lack/grant=%b%b%b%b%b, want 0000%b",
               name, m_frame, m_req, h_ack, l_ack, grant, onehot(src));
    end
    cyc();
  endtask

  task automatic test_reset();
    nrst = 0; h_frame = 0; l_frame = 0; h_rdy = 0; l_rdy = 0; m_ack = 0;
    h_data = 0; l_data = 0;
    model_last = 1; model_aborts = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int pass = 0; pass < 2; pass++) begin
      n_run++;
      if ({m_frame, m_req, h_ack, l_ack, err_timeout} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset%0d ctl: got %b%b%b%b%b, want 00000", pass, m_frame, m_req, h_ack, l_ack, err_timeout);
      end
      n_run++;
      if (grant !== 2'b00) begin n_fail++; $display("FAIL reset%0d grant: got %b, want 00", pass, grant); end
      n_run++;
      if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset%0d m_data: got %h, want 00", pass, m_data); end
      n_run++;
      if (abort_cnt !== 8'h00) begin n_fail++; $display("FAIL reset%0d abort_cnt: got %0d, want 0", pass, abort_cnt); end
      if (pass == 0) begin
        @(negedge clk);
        nrst = 1;
        cyc();
        h_rdy = 1; l_rdy = 1; m_ack = 1; h_data = 8'($urandom); l_data = 8'($urandom);
        cyc();
      end
    end
    idle(2);
  endtask

  task automatic test_simultaneous();
    bit own;
    h_frame = 1; l_frame = 1;
    own = pick_owner(1, 1);
    wait_grant(own, 1, "simul_first");
    xfer(own, $urandom_range(3, 8), "simul_first");
    own = pick_owner(h_frame, l_frame);
    wait_grant(own, GAP + 1, "simul_second");
    xfer(own, $urandom_range(3, 8), "simul_second");
    h_frame = 1; l_frame = 1;
    own = pick_owner(1, 1);
    wait_grant(own, GAP + 1, "simul_rr");
    xfer(own, $urandom_range(3, 8), "simul_rr");
    own = pick_owner(h_frame, l_frame);
    wait_grant(own, GAP + 1, "gap_pending");
    xfer(own, $urandom_range(3, 8), "gap_pending");
    idle(GAP + 2);
  endtask

  task automatic test_host_only();
    h_frame = 1;
    wait_grant(pick_owner(1, 0), 1, "host_only");
    xfer(0, 5, "host_only");
    idle(GAP + 2);
  endtask

  task automatic test_timeout();
    int k;
    int at = 0;
    bit seen = 0;
    h_frame = 1; h_rdy = 0; m_ack = 0;
    wait_grant(0, 1, "timeout");
    k = $urandom_range(0, 5);
    repeat (k) cyc();
    h_rdy = 1; h_data = 8'h5A; m_ack = 1;
    cyc();
    h_rdy = 0; m_ack = 0;
    for (int c = 1; c <= TMO + 4 && !seen; c++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) begin
        seen = 1;
        at = c;
      end else begin
        n_run++;
        if (m_frame !== 1'b1) begin n_fail++; $display("FAIL timeout hold c%0d: got m_frame=%b, want 1", c, m_frame); end
        cyc();
      end
    end
    n_run++;
    if (!seen || at != TMO + 1) begin
      n_fail++;
      $display("FAIL timeout_at: got cycle %0d (seen=%0b), want %0d", at, seen, TMO + 1);
    end
    model_aborts++;
    n_run++;
    if ({m_frame, m_req, grant} !== 4'b0001) begin
      n_fail++;
      $display("FAIL timeout abort: got frame/req/grant=%b%b%b, want 0001", m_frame, m_req, grant);
    end
    n_run++;
    if (abort_cnt !== sat_aborts()) begin
      n_fail++;
      $display("FAIL timeout abort_cnt: got %0d, want %0d", abort_cnt, sat_aborts());
    end
    cyc();
    for (int i = 0; i < 3; i++) begin
      h_rdy = 1; h_data = 8'($urandom); l_rdy = 1; m_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_run++;
      if ({err_timeout, m_frame, m_req, h_ack, l_ack, grant, m_data} !== {5'b00010, 2'b01, 8'h00}) begin
        n_fail++;
        $display("FAIL drain byte %0d: got err/frame/req/hack/lack=%b%b%b%b%b grant=%b data=%h, want 00010 01 00",
                 i, err_timeout, m_frame, m_req, h_ack, l_ack, grant, m_data);
      end
      cyc();
    end
    h_frame = 0; h_rdy = 0; l_rdy = 0; m_ack = 0;
    cyc();
    @(negedge clk);
    n_run++;
    if ({grant, m_frame, h_ack} !== 4'b0000) begin
      n_fail++;
      $display("FAIL drain exit: got grant=%b frame=%b hack=%b, want gap (0000)", grant, m_frame, h_ack);
    end
    idle(GAP + 2);
  endtask

  task automatic test_boundary();
    h_frame = 1; h_rdy = 0; m_ack = 0;
    wait_grant(0, 1, "boundary");
    repeat (TMO - 2) cyc();
    h_frame = 0;
    @(negedge clk);
    n_run++;
    if ({m_frame, err_timeout} !== 2'b00) begin
      n_fail++;
      $display("FAIL boundary drop: got frame=%b err=%b, want 00", m_frame, err_timeout);
    end
    cyc();
    @(negedge clk);
    n_run++;
    if ({grant, err_timeout, m_frame} !== 4'b0000) begin
      n_fail++;
      $display("FAIL boundary gap: got grant=%b err=%b frame=%b, want 0000", grant, err_timeout, m_frame);
    end
    n_run++;
    if (abort_cnt !== sat_aborts()) begin
      n_fail++;
      $display("FAIL boundary abort_cnt: got %0d, want %0d", abort_cnt, sat_aborts());
    end
    idle(GAP + 2);
  endtask

  task automatic test_saturate();
    bit src, seen;
    for (int it = 0; it < 256; it++) begin
      src = 1'($urandom_range(0, 1));
      seen = 0;
      if (src) l_frame = 1; else h_frame = 1;
      h_rdy = 0; l_rdy = 0; m_ack = 0;
      for (int c = 0; c < 60 && !seen; c++) begin
        @(negedge clk);
        if (err_timeout === 1'b1) begin
          seen = 1;
          model_aborts++;
          n_run++;
          if (abort_cnt !== sat_aborts() || grant !== onehot(src)) begin
            n_fail++;
            $display("FAIL sat iter %0d: got cnt=%0d grant=%b, want cnt=%0d grant=%b",
                     it, abort_cnt, grant, sat_aborts(), onehot(src));
          end
        end
        cyc();
      end
      n_run++;
      if (!seen) begin n_fail++; $display("FAIL sat iter %0d: got no err_timeout, want one", it); end
      model_last = src;
      h_frame = 0; l_frame = 0;
      cyc();
    end
    @(negedge clk);
    n_run++;
    if (abort_cnt !== 8'd255) begin n_fail++; $display("FAIL sat final: got %0d, want 255", abort_cnt); end
    cyc();
    idle(GAP + 2);
  endtask

  task automatic test_reset_mid_frame();
    bit own;
    l_frame = 1; l_rdy = 0; m_ack = 0;
    wait_grant(pick_owner(0, 1), 1, "rst_mid");
    repeat (2) begin
      l_rdy = 1; l_data = 8'($urandom); m_ack = 1;
      cyc();
    end
    #2 nrst = 0;
    model_last = 1; model_aborts = 0;
    #1;
    n_run++;
    if ({m_frame, m_req, h_ack, l_ack, grant, err_timeout, m_data, abort_cnt} !== 22'd0) begin
      n_fail++;
      $display("FAIL rst_mid async: got frame/req/hack/lack=%b%b%b%b grant=%b err=%b data=%h cnt=%0d, want all 0",
               m_frame, m_req, h_ack, l_ack, grant, err_timeout, m_data, abort_cnt);
    end
    @(negedge clk);
    nrst = 1;
    #1;
    n_run++;
    if ({grant, m_frame} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid release: got grant=%b frame=%b, want 000", grant, m_frame);
    end
    cyc();
    @(negedge clk);
    n_run++;
    if ({grant, m_frame, l_ack} !== 4'b1011) begin
      n_fail++;
      $display("FAIL rst_mid regrant: got grant=%b frame=%b lack=%b, want 10 1 1", grant, m_frame, l_ack);
    end
    model_last = 1;
    cyc();
    l_frame = 0; l_rdy = 0; m_ack = 0;
    cyc();
    h_frame = 1; l_frame = 1;
    own = pick_owner(1, 1);
    wait_grant(own, GAP + 1, "rr_after_reset");
    xfer(own, $urandom_range(3, 6), "rr_after_reset");
    own = pick_owner(h_frame, l_frame);
    wait_grant(own, GAP + 1, "rr_after_reset2");
    xfer(own, $urandom_range(3, 6), "rr_after_reset2");
    idle(GAP + 2);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation exceeded time limit, want completion");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    test_reset();
    test_simultaneous();
    test_host_only();
    test_timeout();
    test_boundary();
    test_saturate();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
